// File: rtl/alu_pkg.sv
// Shared definitions for the iterative signed divider: width, FSM encoding and latency.
package alu_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned DIV_LATENCY = 34;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        FIX,
        DONE
    } state_e;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

endpackage

// File: rtl/thirty_two_bit_div_if.sv
// Operand/start and result/ready bundle of the signed divider.
interface thirty_two_bit_div_if;
    import alu_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic [WIDTH-1:0] data_remainder;
    logic             data_exception;
    logic             data_resultRDY;

    modport master (
        output data_operandA, data_operandB, ctrl_DIV,
        input  data_result, data_remainder, data_exception, data_resultRDY
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_DIV,
        output data_result, data_remainder, data_exception, data_resultRDY
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // Partial remainder stays below the divisor, so the shifted value fits in 33 bits
    // and the top bit of the difference is a clean borrow.
    always_comb begin
        w_shift = {i_rem, i_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, i_div};
        if (w_diff[WIDTH]) begin
            o_rem = w_shift[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b0};
        end else begin
            o_rem = w_diff[WIDTH-1:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/thirty_two_bit_div.sv
// 32-bit signed divider: magnitude restoring division over 32 cycles, then sign fix-up.
module thirty_two_bit_div
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clock,
    input logic                  reset_n,
    thirty_two_bit_div_if.slave  bus
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic [4:0]       r_cnt;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_ovf;
    logic             r_zero;
    logic             r_exc;
    logic             r_rdy;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_zero_b;

    assign w_zero_b = (bus.data_operandB == '0);

    div_step u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_div       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exc       <= 1'b0;
            r_rdy       <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            r_exc <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (bus.ctrl_DIV) begin
                        r_a     <= bus.data_operandA;
                        r_b     <= bus.data_operandB;
                        r_zero  <= w_zero_b;
                        r_state <= w_zero_b ? DONE : SETUP;
                    end
                end
                SETUP: begin
                    r_quo  <= abs_val(r_a);
                    r_div  <= abs_val(r_b);
                    r_rem  <= '0;
                    r_qneg <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_rneg <= r_a[WIDTH-1];
                    r_ovf  <= (r_a == MIN_NEG) && (r_b == '1);
                    r_cnt  <= '0;
                    r_zero <= (r_b == '0);
                    r_state <= (r_b == '0) ? DONE : RUN;
                end
                RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!bus.ctrl_DIV) begin
                        r_result    <= r_qneg ? -r_quo : r_quo;
                        r_remainder <= r_rneg ? -r_rem : r_rem;
                        r_exc       <= r_ovf;
                        r_rdy       <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Divide-by-zero skips FIX, so its results are published on leaving DONE.
                    if (r_zero) begin
                        r_result    <= '0;
                        r_remainder <= r_a;
                        r_exc       <= 1'b1;
                        r_rdy       <= 1'b1;
                    end
                    if (bus.ctrl_DIV) begin
                        r_a     <= bus.data_operandA;
                        r_b     <= bus.data_operandB;
                        r_zero  <= w_zero_b;
                        r_state <= w_zero_b ? DONE : SETUP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (bus.ctrl_DIV && (r_state inside {SETUP, RUN, FIX})) begin
                r_a     <= bus.data_operandA;
                r_b     <= bus.data_operandB;
                r_state <= SETUP;
            end
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_remainder = r_remainder;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;

endmodule

// File: tb/tb_thirty_two_bit_div.sv
// Scoreboard bench for thirty_two_bit_div: expected results queued at start, checked on ready.
module tb_thirty_two_bit_div;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          edge_no;
    } exp_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   cyc     = 0;
    int   errors  = 0;
    int   checks  = 0;
    exp_t sb_q[$];

    thirty_two_bit_div_if bus ();

    thirty_two_bit_div #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        exp_t x;
        if (bus.data_resultRDY === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_rdy: rdy=1 after edge %0d, required no pulse", cyc);
            end else begin
                x = sb_q.pop_front();
                checks++;
                if (cyc !== x.edge_no) begin
                    errors++;
                    $display("FAIL latency: rdy after edge %0d, required edge %0d", cyc, x.edge_no);
                end
                checks++;
                if (bus.data_result !== x.q) begin
                    errors++;
                    $display("FAIL result: got %h, required %h", bus.data_result, x.q);
                end
                checks++;
                if (bus.data_remainder !== x.r) begin
                    errors++;
                    $display("FAIL remainder: got %h, required %h", bus.data_remainder, x.r);
                end
                checks++;
                if (bus.data_exception !== x.e) begin
                    errors++;
                    $display("FAIL exception: got %b, required %b", bus.data_exception, x.e);
                end
            end
        end else if (cyc >= 3) begin
            checks++;
            if (bus.data_exception !== 1'b0) begin
                errors++;
                $display("FAIL exc_without_rdy: exception=%b at edge %0d, required 0",
                         bus.data_exception, cyc);
            end
        end
    end

    task automatic start_div(input logic [31:0] a, input logic [31:0] b, input bit sync,
                             input bit track, input logic [31:0] eq, input logic [31:0] er,
                             input logic ee, input int lat);
        if (sync) @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_DIV      = 1'b1;
        if (track) sb_q.push_back('{eq, er, ee, cyc + 1 + lat});
        @(negedge clock);
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (bus.data_result !== 32'h0) begin
            errors++;
            $display("FAIL %s_result: got %h, required 0", tag, bus.data_result);
        end
        checks++;
        if (bus.data_remainder !== 32'h0) begin
            errors++;
            $display("FAIL %s_remainder: got %h, required 0", tag, bus.data_remainder);
        end
        checks++;
        if (bus.data_exception !== 1'b0) begin
            errors++;
            $display("FAIL %s_exception: got %b, required 0", tag, bus.data_exception);
        end
        checks++;
        if (bus.data_resultRDY !== 1'b0) begin
            errors++;
            $display("FAIL %s_rdy: got %b, required 0", tag, bus.data_resultRDY);
        end
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'h0;
        bus.data_operandB = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outputs("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        start_div(32'd100, 32'd7, 1'b1, 1'b1, 32'd14, 32'd2, 1'b0, DIV_LATENCY);
        wait_drain(60);
    endtask

    task automatic test_signs();
        // -100 = FFFFFF9C, -7 = FFFFFFF9, -14 = FFFFFFF2, -2 = FFFFFFFE
        logic [31:0] ta[3] = '{32'hFFFFFF9C, 32'd100,      32'hFFFFFF9C};
        logic [31:0] tb[3] = '{32'd7,        32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] tq[3] = '{32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14};
        logic [31:0] tr[3] = '{32'hFFFFFFFE, 32'd2,        32'hFFFFFFFE};
        for (int i = 0; i < 3; i++) begin
            start_div(ta[i], tb[i], 1'b1, 1'b1, tq[i], tr[i], 1'b0, DIV_LATENCY);
            wait_drain(60);
        end
    endtask

    task automatic test_div_zero();
        start_div(32'd5, 32'd0, 1'b1, 1'b1, 32'd0, 32'd5, 1'b1, 1);
        wait_drain(10);
        start_div(32'hFFFFFFF7, 32'd0, 1'b1, 1'b1, 32'd0, 32'hFFFFFFF7, 1'b1, 1);
        wait_drain(10);
    endtask

    task automatic test_overflow();
        start_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'd0, 1'b1,
                  DIV_LATENCY);
        wait_drain(60);
    endtask

    task automatic test_abort();
        start_div(32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (9) @(negedge clock);
        start_div(32'd9, 32'd2, 1'b0, 1'b1, 32'd4, 32'd1, 1'b0, DIV_LATENCY);
        wait_drain(80);
    endtask

    task automatic test_hold();
        repeat (5) begin
            @(negedge clock);
            bus.data_operandA = $urandom;
            bus.data_operandB = $urandom;
        end
        checks++;
        if (bus.data_result !== 32'd4) begin
            errors++;
            $display("FAIL hold_result: got %h, required 4", bus.data_result);
        end
        checks++;
        if (bus.data_remainder !== 32'd1) begin
            errors++;
            $display("FAIL hold_remainder: got %h, required 1", bus.data_remainder);
        end
    endtask

    task automatic test_reset_abort();
        start_div(32'd100, 32'd7, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        repeat (19) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        check_zero_outputs("midreset");
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        start_div(32'd6, 32'd3, 1'b1, 1'b1, 32'd2, 32'd0, 1'b0, DIV_LATENCY);
        wait_drain(60);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        int          sa;
        int          sb;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 2 == 1) b = b >>> $urandom_range(28, 0);
            if (b == 32'h0) b = 32'd3;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd5;
            sa = int'(a);
            sb = int'(b);
            start_div(a, b, 1'b1, 1'b1, 32'(sa / sb), 32'(sa % sb), 1'b0, DIV_LATENCY);
            wait_drain(60);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        start_div(32'd1000, 32'd9, 1'b1, 1'b1, 32'd111, 32'd1, 1'b0, DIV_LATENCY);
        while (bus.data_resultRDY !== 1'b1 && n < 60) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (bus.data_resultRDY !== 1'b1) begin
            errors++;
            $display("FAIL b2b_wait: rdy=%b after %0d cycles, required 1", bus.data_resultRDY, n);
        end
        // -1000 = FFFFFC18, -111 = FFFFFF91, -1 = FFFFFFFF
        start_div(32'hFFFFFC18, 32'd9, 1'b0, 1'b1, 32'hFFFFFF91, 32'hFFFFFFFF, 1'b0,
                  DIV_LATENCY);
        wait_drain(60);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_overflow();
        test_abort();
        test_hold();
        test_reset_abort();
        test_random();
        test_back_to_back();
        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thirty_two_bit_div.md
THIRTY_TWO_BIT_DIV -- requirements
Module: thirty_two_bit_div

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 data_operandA  input  32  signed dividend, sampled only on the edge where ctrl_DIV=1.
REQ-005 data_operandB  input  32  signed divisor, sampled only on the edge where ctrl_DIV=1.
REQ-006 ctrl_DIV  input  1  start pulse; ctrl_DIV=1 at an edge starts a division.
REQ-007 data_result  output  32  signed quotient; registered.
REQ-008 data_remainder  output  32  signed remainder; registered.
REQ-009 data_exception  output  1  divide-by-zero or overflow flag, valid when data_resultRDY=1.
REQ-010 data_resultRDY  output  1  one-cycle completion pulse.

Function
REQ-011 Arithmetic: two's-complement signed division; quotient truncates toward zero; remainder sign equals dividend sign; |remainder| < |divisor|.
REQ-012 FSM states: IDLE, SETUP, RUN, FIX, DONE.
REQ-013 IDLE: ctrl_DIV=1 -> latch operands and go to SETUP; ctrl_DIV=0 -> stay.
REQ-014 SETUP (1 cycle): take absolute values; record quotient sign (A[31]^B[31]) and remainder sign (A[31]); clear iteration counter; go to RUN.
REQ-015 RUN: one restoring shift-subtract step per cycle for exactly 32 cycles (counter 0..31); go to FIX after step 31.
REQ-016 FIX (1 cycle): apply sign correction; load data_result and data_remainder; go to DONE.
REQ-017 DONE: data_resultRDY=1 for exactly this one cycle; go to IDLE (or SETUP if ctrl_DIV=1 on that edge).
REQ-018 Latency: with ctrl_DIV sampled at edge N, data_resultRDY is high in the cycle after edge N+34.
REQ-019 Divide by zero (B=0): go IDLE->DONE directly; data_result=0, data_remainder=A, data_exception=1; data_resultRDY high in the cycle after edge N+1.
REQ-020 Overflow (A=0x80000000, B=0xFFFFFFFF): full latency; data_result=0x80000000, data_remainder=0, data_exception=1.
REQ-021 Otherwise data_exception=0 while data_resultRDY=1.
REQ-022 data_exception SHALL be 0 whenever data_resultRDY=0.
REQ-023 ctrl_DIV=1 in SETUP, RUN or FIX aborts the current operation, relatches operands, and goes to SETUP; no data_resultRDY is issued for the aborted operation.
REQ-024 data_result and data_remainder hold their last completed values until the next FIX or divide-by-zero DONE.
REQ-025 Operand inputs are ignored except on an edge where ctrl_DIV=1.

Reset
REQ-026 reset_n=0 at an edge: state=IDLE, counter=0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0.
REQ-027 Reset SHALL take priority over ctrl_DIV and abort any operation in progress without a data_resultRDY pulse.

Structure
REQ-028 Shared package alu_pkg holds WIDTH, the state enumeration and DIV_LATENCY=34.
REQ-029 One combinational sub-module, div_step, implements a single restoring iteration: (partial remainder, quotient, abs divisor) -> next pair.
REQ-030 The datapath uses one 33-bit subtractor inside div_step; no multi-cycle paths and no combinational path from inputs to outputs.

Verification
REQ-031 100/7 -> data_result=14, data_remainder=2, exception=0, data_resultRDY high the cycle after edge N+34.
REQ-032 -100/7 -> data_result=-14 (0xFFFFFFF2), data_remainder=-2, exception=0; 100/-7 -> -14, remainder 2.
REQ-033 5/0 -> data_result=0, data_remainder=5, exception=1, data_resultRDY the cycle after edge N+1.
REQ-034 0x80000000/0xFFFFFFFF -> data_result=0x80000000, data_remainder=0, exception=1 at full latency.
REQ-035 Start 100/7, pulse ctrl_DIV with 9/2 at edge N+10 -> single data_resultRDY at edge N+44 with 4, remainder 1.
REQ-036 reset_n=0 at edge N+20 of a division -> all outputs 0, no data_resultRDY; next 6/3 -> 2, remainder 0.
